// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, keeps one imem request outstanding at a time,
// and hands {inst, pc, err} to decode. Execute redirects kill any wrong-path fetch.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_err,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] inst_q, inst_nx;
    logic [31:0] cnt_nx;
    logic        drop, drop_nx;
    logic        err_q, err_nx;
    logic [31:0] redir_pc;
    logic        req_fire;

    assign redir_pc = redirect_pc & 32'hFFFF_FFFC;
    assign req_fire = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            inst_q      <= INST_NOP;
            err_q       <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            drop        <= drop_nx;
            inst_q      <= inst_nx;
            err_q       <= err_nx;
            fetch_count <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        drop_nx  = drop;
        inst_nx  = inst_q;
        err_nx   = err_q;
        cnt_nx   = fetch_count;
        case (state)
            S_REQ: begin
                if (redirect_valid) pc_nx = redir_pc;
                if (req_fire) begin
                    state_nx = S_WAIT;
                    // a redirect racing the handshake leaves a stale request in flight
                    drop_nx  = redirect_valid;
                end
            end
            S_WAIT: begin
                if (redirect_valid) pc_nx = redir_pc;
                if (imem_rsp_valid) begin
                    if (drop || redirect_valid) begin
                        state_nx = S_REQ;
                        drop_nx  = 1'b0;
                    end else begin
                        state_nx = S_HOLD;
                        inst_nx  = imem_rsp_data;
                        err_nx   = imem_rsp_err;
                    end
                end else if (redirect_valid) begin
                    drop_nx = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_nx    = redir_pc;
                    state_nx = S_REQ;
                end else if (out_ready) begin
                    pc_nx    = pc + 32'd4;
                    cnt_nx   = fetch_count + 32'd1;
                    state_nx = S_REQ;
                end
            end
            default: state_nx = S_REQ;
        endcase
    end

    // rst gates the request so nothing is presented while the core is held in reset
    assign imem_req_valid = rst && (state == S_REQ);
    assign imem_req_addr  = pc;
    assign out_valid      = (state == S_HOLD) && !redirect_valid;
    assign out_inst       = (state == S_HOLD) ? inst_q : INST_NOP;
    assign out_err        = (state == S_HOLD) && err_q;
    assign out_pc         = pc;

    a_rsp_in_wait: assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> state == S_WAIT);

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: expected request addresses and decode outputs are
// queued as stimulus is driven and compared when the DUT hands them out.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid, imem_rsp_err;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_inst, out_pc, fetch_count;

    ifu_fetch #(.RESET_PC(RESET_PC), .INST_NOP(INST_NOP)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .imem_rsp_err(imem_rsp_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_err(out_err), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          exp_cnt = 0;
    int          mem_lat = 0;
    logic [31:0] err_addr = 32'hFFFF_FFF0;
    logic [31:0] req_q[$];
    logic [64:0] out_q[$];   // {err, pc, inst}

    // memory model state
    logic        m_pend = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_addr = 32'd0;
    logic        m_hs = 1'b0;
    logic [31:0] m_hs_addr = 32'd0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0093 : (a ^ 32'h5A5A_0003);
    endfunction

    function automatic logic [64:0] exp_out(input logic [31:0] a);
        return {a == err_addr, a, mem_data(a)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory: handshake sampled mid-cycle, response pulsed mem_lat cycles into S_WAIT.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        imem_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            m_hs      = rst && imem_req_valid && imem_req_ready;
            m_hs_addr = imem_req_addr;
            if (!rst) m_pend = 1'b0;
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            imem_rsp_err   = 1'b0;
            if (!rst) begin
                m_pend = 1'b0;
            end else begin
                if (m_hs) begin
                    m_pend = 1'b1;
                    m_cnt  = mem_lat;
                    m_addr = m_hs_addr;
                end
                if (m_pend) begin
                    if (m_cnt == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = mem_data(m_addr);
                        imem_rsp_err   = (m_addr == err_addr);
                        m_pend         = 1'b0;
                    end else begin
                        m_cnt--;
                    end
                end
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            if (imem_req_valid && imem_req_ready) begin
                if (req_q.size() == 0) chk("req_unexpected", {31'd0, imem_req_valid}, 32'd0);
                else                   chk("req_addr", imem_req_addr, req_q.pop_front());
            end
            if (out_valid && out_ready) begin
                if (out_q.size() == 0) begin
                    chk("out_unexpected", {31'd0, out_valid}, 32'd0);
                end else begin
                    logic [64:0] e;
                    e = out_q.pop_front();
                    chk("out_pc", out_pc, e[63:32]);
                    chk("out_inst", out_inst, e[31:0]);
                    chk("out_err", {31'd0, out_err}, {31'd0, e[64]});
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_out(input int lim);
        int i = 0;
        while (!out_valid && i < lim) begin
            cyc(1);
            i++;
        end
        if (!out_valid) chk("out_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic consume();
        wait_out(20);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        exp_cnt++;
        chk("fetch_count", fetch_count, exp_cnt);
    endtask

    task automatic kill(input logic [31:0] npc);
        wait_out(20);
        redirect_valid = 1'b1;
        redirect_pc    = npc;
        out_ready      = 1'b1;
        #1;
        chk("kill_valid", {31'd0, out_valid}, 32'd0);
        cyc(1);
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        chk("kill_count", fetch_count, exp_cnt);
    endtask

    initial begin
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b0;
        cyc(2);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_inst", out_inst, INST_NOP);
        chk("rst_out_pc", out_pc, RESET_PC);
        chk("rst_fetch_count", fetch_count, 32'd0);

        // first fetch, then decode stalls for 5 cycles
        req_q.push_back(RESET_PC);
        out_q.push_back(exp_out(RESET_PC));
        rst = 1'b1;
        #1;
        chk("first_req_addr", imem_req_addr, RESET_PC);
        cyc(2);
        chk("first_out_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("stall_pc", out_pc, RESET_PC);
            chk("stall_inst", out_inst, 32'h0000_0093);
            chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
            chk("stall_count", fetch_count, 32'd0);
        end
        req_q.push_back(32'h8000_0004);
        mem_lat = 2;
        consume();
        chk("next_req_addr", imem_req_addr, 32'h8000_0004);

        // redirect while waiting; stale response arrives 2 cycles later
        cyc(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        req_q.push_back(32'h8000_0100);
        out_q.push_back(exp_out(32'h8000_0100));
        cyc(1);
        redirect_valid = 1'b0;
        mem_lat = 0;
        consume();

        // redirect in S_HOLD with out_ready high; unaligned target
        req_q.push_back(32'h8000_0104);
        wait_out(20);
        imem_req_ready = 1'b0;
        req_q.push_back(32'h8000_0200);
        err_addr = 32'h8000_0200;
        out_q.push_back(exp_out(32'h8000_0200));
        kill(32'h8000_0203);

        // memory not ready for 4 cycles, then a faulting fetch
        for (int i = 0; i < 4; i++) begin
            chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("stall_req_addr", imem_req_addr, 32'h8000_0200);
            cyc(1);
        end
        imem_req_ready = 1'b1;
        wait_out(20);
        chk("fault_err", {31'd0, out_err}, 32'd1);
        chk("fault_pc", out_pc, 32'h8000_0200);
        req_q.push_back(32'h8000_0204);
        consume();

        // PC wrap at the top of the address space
        wait_out(20);
        req_q.push_back(32'hFFFF_FFFC);
        out_q.push_back(exp_out(32'hFFFF_FFFC));
        kill(32'hFFFF_FFFF);
        consume();
        req_q.push_back(32'h0000_0000);
        chk("wrap_addr", imem_req_addr, 32'h0000_0000);

        // async reset while a request is outstanding
        mem_lat = 3;
        cyc(1);
        rst = 1'b0;
        #1;
        exp_cnt = 0;
        chk("arst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_pc", out_pc, RESET_PC);
        chk("arst_out_inst", out_inst, INST_NOP);
        chk("arst_count", fetch_count, 32'd0);
        cyc(2);
        mem_lat = 0;
        req_q.push_back(RESET_PC);
        out_q.push_back(exp_out(RESET_PC));
        rst = 1'b1;
        consume();
        imem_req_ready = 1'b0;
        cyc(3);
        chk("req_q_left", 32'(req_q.size()), 32'd0);
        chk("out_q_left", 32'(out_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1);
    end

endmodule
